sum_normalizer48: RTL and testbench
===================================

Name: sum_normalizer48

Overview:
- Iterative leading-zero normaliser that consumes the 48-bit result of the 47+7-bit mantissa/increment adder stage.
- Left-shifts the value until bit 47 is 1 and reports the shift count, which the downstream exponent-adjust stage uses.
- Multi-cycle, single-entry, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 48, datapath width of the incoming sum and the normalised result.
- SHIFT_STEP, 8, maximum coarse shift per cycle; legal values are 1, 2, 4, 8, 16.
- CNT_W, $clog2(WIDTH+1) = 6, width of the shift count (localparam, not overridable).

Ports:
- clk  in  1  clock; all flops update on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream sum is valid.
- in_ready  out  1  block can accept a sum.
- in_sum  in  WIDTH  48-bit adder result.
- out_valid  out  1  normalised result is valid.
- out_ready  in  1  downstream accepts the result.
- out_mant  out  WIDTH  normalised mantissa; bit 47 = 1 unless out_zero = 1.
- out_shift  out  CNT_W  number of left shifts applied (0..48).
- out_zero  out  1  the input sum was all zeros.

Behaviour:
- Reset (async assert, sync release): state = IDLE, working register = 0, count = 0. Outputs after reset: out_valid = 0, out_mant = 0, out_shift = 0, out_zero = 0, in_ready = 1.
- States: IDLE, SHIFT, DONE.
- in_ready = (state == IDLE), driven combinationally from the state.
- Accept when in_valid && in_ready.
  - If in_sum == 0: load work = 0, cnt = 48, zero = 1, go to DONE.
  - Otherwise: load work = in_sum, cnt = 0, zero = 0, go to SHIFT.
- SHIFT, each cycle: z = leading zeros in work[47 -: SHIFT_STEP].
  - If z == SHIFT_STEP: work <<= SHIFT_STEP, cnt += SHIFT_STEP, stay in SHIFT.
  - Else: work <<= z, cnt += z, go to DONE.
- SHIFT always terminates because work is nonzero. Zeros shifted in at the LSB; no bits are lost beyond the leading zeros.
- DONE:
  - out_valid = 1; out_mant = work, out_shift = cnt, out_zero = zero.
  - Outputs stay stable while out_ready = 0.
  - On out_valid && out_ready, go to IDLE.
- out_valid = 0 in IDLE and SHIFT. out_mant, out_shift and out_zero hold their last values and are don't-care when out_valid = 0.
- Latency, counted from the accept cycle c:
  - zero input: out_valid in cycle c+1.
  - nonzero input: out_valid in cycle c+2+floor(lzc/SHIFT_STEP).
  - Example with SHIFT_STEP = 8: lzc 0 gives 2 cycles; lzc 47 gives 7 cycles.
- Throughput without the optional feature: one result per latency + 1 cycles (the IDLE cycle is mandatory).
- in_sum is sampled only at accept; upstream changes afterwards have no effect.
- The invariant cnt <= 48 is guaranteed by construction.
- Reset mid-operation (SHIFT or DONE): abandon the item immediately and return to the reset values; no partial output is produced.
- in_valid held high while busy: no accept, no side effects.

Optional Feature:
- Macro: NORM_BACK_TO_BACK_EN.
- Defined: in_ready = (state == IDLE) || (state == DONE && out_ready). A handshake on both sides in the same DONE cycle retires the current result and loads the new sum (to SHIFT, or to DONE if the new sum is zero), with no IDLE bubble.
- Undefined: in_ready is high only in IDLE, as described above.

Test Plan:
- Reset, then drive in_sum = 48'h8000_0000_0000 with out_ready = 1 → out_valid in cycle c+2 with out_mant = 48'h8000_0000_0000, out_shift = 0, out_zero = 0.
- in_sum = 48'h0000_0000_0001 → out_valid in cycle c+7 with out_mant = 48'h8000_0000_0000, out_shift = 47.
- in_sum = 0 → out_valid in cycle c+1 with out_zero = 1, out_shift = 48, out_mant = 0.
- in_sum = 48'h00F0_0000_0000 (lzc 8); hold out_ready = 0 for 5 cycles, keep in_valid high with a new value → outputs stable with out_mant = 48'hF000_0000_0000, out_shift = 8; in_ready = 0 throughout; second item accepted only after the handshake.
- Assert rst_n = 0 while in SHIFT with in_sum = 48'h0000_0100_0000 → out_valid = 0 and in_ready = 1 right after reset; a following input 48'h4000_0000_0000 yields out_shift = 1.
- With NORM_BACK_TO_BACK_EN and SHIFT_STEP = 1: stream 48'h8000_0000_0000 then 48'h4000_0000_0000 with in_valid and out_ready held high → second accept occurs in the first item's DONE cycle; results out_shift = 0, then out_shift = 1, with no idle cycle between accepts.

Source files
------------

// File: rtl/sum_normalizer48.sv
// sum_normalizer48: iterative leading-zero normaliser for the 48-bit adder sum.
// Optional macro NORM_BACK_TO_BACK_EN: accept a new sum in the DONE retire cycle.
module sum_normalizer48 #(
    parameter int   WIDTH      = 48,
    parameter int   SHIFT_STEP = 8,
    localparam int  CNT_W      = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mant,
    output logic [CNT_W-1:0] out_shift,
    output logic             out_zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] STEP_C = CNT_W'(SHIFT_STEP);
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               zero_q, zero_d;

    logic [CNT_W-1:0]   lz;
    logic               lz_found;
    logic               accept;
    logic               sum_is_zero;

    // Handshake readiness: IDLE only, or also the retiring DONE cycle.
`ifdef NORM_BACK_TO_BACK_EN
    assign in_ready = (state_q == IDLE) ||
                      ((state_q == DONE) && out_ready);
`else
    assign in_ready = (state_q == IDLE);
`endif

    assign accept      = in_valid && in_ready;
    assign sum_is_zero = (in_sum == '0);

    assign out_valid = (state_q == DONE);
    assign out_mant  = work_q;
    assign out_shift = cnt_q;
    assign out_zero  = zero_q;

    // Leading zeros inside the top SHIFT_STEP bits of the working value.
    always_comb begin
        lz       = STEP_C;
        lz_found = 1'b0;
        for (int i = 0; i < SHIFT_STEP; i++) begin
            if (!lz_found && work_q[WIDTH-1-i]) begin
                lz       = CNT_W'(i);
                lz_found = 1'b1;
            end
        end
    end

    // Next-state and datapath update; a new accept overrides the case result.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        unique case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            SHIFT: begin
                work_d = work_q << lz;
                cnt_d  = cnt_q + lz;
                if (lz != STEP_C) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (accept) begin
            if (sum_is_zero) begin
                work_d  = '0;
                cnt_d   = FULL_C;
                zero_d  = 1'b1;
                state_d = DONE;
            end else begin
                work_d  = in_sum;
                cnt_d   = '0;
                zero_d  = 1'b0;
                state_d = SHIFT;
            end
        end
    end

    // State and datapath registers; reset abandons any item in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
        end
    end

endmodule

// File: tb/tb_sum_normalizer48.sv
// tb_sum_normalizer48: scoreboard bench for sum_normalizer48.
// Expected results come from a direct leading-zero model.
module tb_sum_normalizer48;

`ifdef NORM_BACK_TO_BACK_EN
    localparam int STEP = 1;
    localparam int B2B  = 1;
`else
    localparam int STEP = 8;
    localparam int B2B  = 0;
`endif

    typedef struct {
        logic [47:0] mant;
        logic [5:0]  sh;
        logic        z;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [47:0] in_sum = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [47:0] out_mant;
    logic [5:0]  out_shift;
    logic        out_zero;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc = 0;
    bit   seen = 1'b0;
    exp_t sbq[$];

    sum_normalizer48 #(
        .WIDTH(48),
        .SHIFT_STEP(STEP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_sum(in_sum),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_mant(out_mant),
        .out_shift(out_shift),
        .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [47:0] s);
        exp_t e;
        int   n;
        n = 48;
        for (int i = 47; i >= 0; i--) begin
            if (s[i]) begin
                n = 47 - i;
                break;
            end
        end
        e.acc = 0;
        if (n == 48) begin
            e.mant = '0;
            e.sh   = 6'd48;
            e.z    = 1'b1;
            e.lat  = 1;
        end else begin
            e.mant = s << n;
            e.sh   = 6'(n);
            e.z    = 1'b0;
            e.lat  = 2 + n / STEP;
        end
        return e;
    endfunction

    // Scoreboard monitor: latency on first valid, data every valid cycle.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst_n && out_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out mant=%h shift=%0d", out_mant, out_shift);
            end else begin
                e = sbq[0];
                if (!seen) begin
                    seen = 1'b1;
                    checks++;
                    if ((cyc - e.acc) !== e.lat) begin
                        errors++;
                        $display("FAIL latency got=%0d exp=%0d", cyc - e.acc, e.lat);
                    end
                end
                checks++;
                if (out_mant !== e.mant || out_shift !== e.sh || out_zero !== e.z) begin
                    errors++;
                    $display("FAIL result got=%h/%0d/%b exp=%h/%0d/%b",
                             out_mant, out_shift, out_zero, e.mant, e.sh, e.z);
                end
                if (out_ready) begin
                    void'(sbq.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    // Caller is at a negedge; returns just after the accepting edge.
    task automatic send(input logic [47:0] s);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_sum   = s;
        for (int k = 0; k < 300; k++) begin
            #1;
            if (in_ready) begin
                e = model(s);
                e.acc = cyc;
                last_acc = cyc;
                sbq.push_back(e);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout sum=%h got=0 exp=1", s);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 300; k++) begin
            if (sbq.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got=%0d exp=0", sbq.size());
            sbq.delete();
            seen = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({out_valid, in_ready, out_mant, out_shift, out_zero} !==
            {1'b0, 1'b1, 48'h0, 6'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got=%b/%b/%h/%0d/%b exp=0/1/0/0/0",
                     out_valid, in_ready, out_mant, out_shift, out_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single(input logic [47:0] s);
        @(negedge clk);
        out_ready = 1'b1;
        send(s);
        drain();
    endtask

    task automatic test_mixed();
        logic [47:0] v;
        test_single(48'h0100_0000_0000);
        test_single(48'h0080_0000_0000);
        test_single(48'h0040_0000_0000);
        test_single(48'h0000_8000_0000);
        for (int i = 0; i < 6; i++) begin
            v = {$urandom, $urandom} >> $urandom_range(0, 47);
            test_single(v);
        end
    endtask

    task automatic test_backpressure();
        int hs;
        bit got;
        @(negedge clk);
        out_ready = 1'b0;
        send(48'h00F0_0000_0000);
        @(negedge clk);
        in_valid = 1'b1;
        in_sum   = 48'h1234_5678_9ABC;
        got = 1'b0;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL bp_valid_timeout got=0 exp=1");
        end
        for (int k = 0; k < 5; k++) begin
            if (k != 0) begin
                @(negedge clk);
                #1;
            end
            checks++;
            if (in_ready !== 1'b0 || out_mant !== 48'hF000_0000_0000 ||
                out_shift !== 6'd8 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_stall got=%b/%h/%0d/%b exp=0/f00000000000/8/1",
                         in_ready, out_mant, out_shift, out_valid);
            end
        end
        out_ready = 1'b1;
        hs = cyc;
        send(48'h1234_5678_9ABC);
        checks++;
        if (last_acc !== hs + 1 - B2B) begin
            errors++;
            $display("FAIL bp_accept_cycle got=%0d exp=%0d", last_acc, hs + 1 - B2B);
        end
        drain();
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        out_ready = 1'b1;
        send(48'h0000_0100_0000);
        @(negedge clk);
        rst_n = 1'b0;
        sbq.delete();
        seen = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_shift !== 6'd0) begin
            errors++;
            $display("FAIL mid_reset got=%b/%b/%0d exp=0/1/0",
                     out_valid, in_ready, out_shift);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(48'h4000_0000_0000);
        drain();
    endtask

    task automatic test_back_to_back();
        int a1;
        @(negedge clk);
        out_ready = 1'b1;
        send(48'h8000_0000_0000);
        a1 = last_acc;
        @(negedge clk);
        send(48'h4000_0000_0000);
        checks++;
        if (last_acc - a1 !== 2 + 1 - B2B) begin
            errors++;
            $display("FAIL b2b_gap got=%0d exp=%0d", last_acc - a1, 3 - B2B);
        end
        @(negedge clk);
        send(48'h0);
        @(negedge clk);
        send(48'h0000_0000_0003);
        drain();
    endtask

    initial begin
        test_reset();
        test_single(48'h8000_0000_0000);
        test_single(48'h0000_0000_0001);
        test_single(48'h0);
        test_single(48'hFFFF_FFFF_FFFF);
        test_mixed();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
